cla_addsub_pipe: RTL and testbench
==================================

# cla_addsub_pipe

Parametrised, pipelined carry-lookahead adder/subtractor for the CPU datapath ALU. It replaces the fixed 32-bit single-cycle adder with configurable width and pipeline depth, add/subtract/carry-chain modes, and status flags. A ready/valid handshake with full backpressure lets it sit between the operand registers and the result bus. Throughput is one operation per cycle.

## Interface
- WIDTH, 32: operand width in bits; must be a multiple of 4 and at least 8.
- STAGES, 2: number of pipeline register stages (1, 2 or 4); WIDTH/4 must be divisible by STAGES.
- clock  in  1  rising-edge clock.
- clear  in  1  reset; synchronous and active-high.
- in_valid  in  1  operands and mode are presented this cycle.
- in_ready  out  1  block accepts the operation this cycle.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B.
- sub  in  1  1 = subtract (x − y), 0 = add.
- use_cin  in  1  1 = carry-in comes from cin (ADC/SBC), 0 = default (0 for add, 1 for sub).
- cin  in  1  external carry/not-borrow input.
- out_valid  out  1  result fields are valid.
- out_ready  in  1  downstream accepts the result this cycle.
- s  out  WIDTH  sum/difference.
- cout  out  1  carry out of the MSB (for sub: 1 = no borrow).
- ovf  out  1  two's-complement overflow.
- zero  out  1  s == 0.
- neg  out  1  s[WIDTH-1].

## Operation
- Effective B: yb = sub ? ~y : y. Effective carry-in: c0 = use_cin ? cin : sub.
- Result: {cout, s} = x + yb + c0, computed modulo 2^(WIDTH+1). Arithmetic is unsigned internally; the flags provide the signed interpretation.
- ovf = (x[MSB] == yb[MSB]) && (s[MSB] != x[MSB]).
- Datapath: WIDTH/4 4-bit groups, each producing group generate (G) and propagate (P).
  - Groups are split evenly into STAGES slices.
  - Slice k uses two-level lookahead (group carries from G/P plus the incoming carry) and registers its sum bits, its carry out, and the upper operand bits still pending.
  - Slice k's carry out feeds slice k+1 in the next stage. There is no ripple across slices within a cycle.
- Pipeline control: each stage holds a valid bit.
  - A stage loads when it is empty or when its content moves on this cycle.
  - The last stage moves on when out_valid && out_ready.
  - in_ready = !v[0] || stage 0 moves on. This is combinational from out_ready through the chain of valid bits.
- Transfer at the input occurs on in_valid && in_ready. Transfer at the output occurs on out_valid && out_ready.
- Stalls: while out_valid && !out_ready, all output fields hold stable, and no stage overwrites a valid entry.
- Operation order is preserved. No operation is dropped or duplicated.
- zero and neg are computed from the final s in the last stage and registered with it.

## Timing
- Latency: an operation accepted at edge n appears with out_valid=1 after edge n+STAGES, provided there is no backpressure.
- Throughput: 1 op/cycle while out_ready=1. Back-to-back inputs produce back-to-back outputs.
- Capacity: STAGES operations in flight. With out_ready held 0, in_ready drops after STAGES accepts.
- Reset: on clear=1 at a rising edge, all stage valid bits become 0, and s, cout, ovf, zero, neg become 0.
  - out_valid = 0 from the cycle after reset.
  - in_ready = 1 whenever clear is not asserted and the pipeline is empty.
  - Operations in flight are discarded.
  - in_valid is ignored in the reset cycle.
- Clear mid-stream takes effect at that edge regardless of handshake state. No partial result is emitted afterward.
- Simultaneous accept and emit on a full pipeline: both happen in the same cycle, and occupancy is unchanged.
- STAGES=1: the block is purely registered single-cycle. Result at edge n+1.
- Wrap-around: carries out of the MSB never affect s; they appear only in cout.

## Test plan
- Add, WIDTH=32, STAGES=2: x=0xFFFF_FFFF, y=0x0000_0001, sub=0, use_cin=0 -> after 2 cycles s=0x0000_0000, cout=1, zero=1, ovf=0, neg=0.
- Sub overflow: x=0x8000_0000, y=0x0000_0001, sub=1 -> s=0x7FFF_FFFF, cout=1, ovf=1, neg=0. Also x=3, y=5, sub=1 -> s=0xFFFF_FFFE, cout=0, neg=1.
- Carry chain, 64-bit add built from two ops (ADC):
  - Low op 0xFFFF_FFFF+1 gives cout=1.
  - High op x=0x0000_0001, y=0, use_cin=1, cin=1 -> s=0x0000_0002.
  - Cross-slice check: x=0x0000_FFFF, y=1 -> s=0x0001_0000.
- Backpressure: with out_ready=0, stream 4 ops.
  - Only 2 are accepted; in_ready=0 afterward; out fields stay stable.
  - Raise out_ready: results exit in order, one per cycle, and new inputs are accepted in the same cycles.
- Reset mid-stream: with 2 ops in flight, pulse clear for 1 cycle -> out_valid=0, all outputs 0, in_ready=1 on the next cycle, and no stale result appears later.
- Parameter sweep: WIDTH∈{8,16,32,64} × STAGES∈{1,2,4} (legal combos), 10k random ops with random in_valid/out_ready against a reference model. Every result and flag matches, and latency equals STAGES when there are no stalls.

Source files
------------

// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: pipelined carry-lookahead adder/subtractor with a
// ready/valid handshake. Each pipeline stage resolves one slice of 4-bit
// groups. The slice carry-out is registered and consumed by the next stage,
// so no carry ripples across slice boundaries within a cycle.
module cla_addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  input  logic             use_cin,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);
  localparam int NG  = WIDTH / 4;
  localparam int GPS = NG / STAGES;
  localparam int SW  = 4 * GPS;
  localparam int L   = STAGES - 1;

  // Group generate/propagate for one 4-bit group.
  function automatic logic [1:0] cla4_gp(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] g;
    p = a ^ b;
    g = a & b;
    return {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]), &p};
  endfunction

  // Sum of one 4-bit group with flattened in-group lookahead.
  function automatic logic [3:0] cla4_sum(input logic [3:0] a, input logic [3:0] b,
                                          input logic ci);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;
    p    = a ^ b;
    g    = a & b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return p ^ c;
  endfunction

  logic [WIDTH-1:0]  yb;
  logic              c0;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] move;
  logic [WIDTH-1:0]  s_nx;
  logic              a_msb;
  logic              b_msb;

  assign yb = sub ? ~y : y;
  assign c0 = use_cin ? cin : sub;

  // Backpressure chain: a stage loads when empty or when its entry advances.
  always_comb begin
    move = '0;
    load = '0;
    move[L] = v_q[L] & out_ready;
    load[L] = ~v_q[L] | move[L];
    for (int k = STAGES - 2; k >= 0; k--) begin
      move[k] = v_q[k] & load[k + 1];
      load[k] = ~v_q[k] | move[k];
    end
  end

  assign in_ready  = ~clear & load[0];
  assign out_valid = v_q[L];

  // Valid bits advance under the same load enables as the data.
  always_ff @(posedge clock) begin
    if (clear) begin
      v_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) v_q[k] <= v_in[k];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // Operand bits still pending at this stage and sum bits resolved so far.
    localparam int PW = WIDTH - k * SW;
    localparam int LW = (k + 1) * SW;

    logic [PW-1:0]  a_in;
    logic [PW-1:0]  b_in;
    logic           c_in;
    logic [SW-1:0]  slice_sum;
    logic [LW-1:0]  sum_nx;
    logic [LW-1:0]  sum_q;
    logic           c_q;
    logic [GPS-1:0] grp_g;
    logic [GPS-1:0] grp_p;
    logic [GPS:0]   grp_c;
    logic           term;
    logic           upd;

    if (k == 0) begin : g_src
      assign a_in    = x;
      assign b_in    = yb;
      assign c_in    = c0;
      assign v_in[0] = in_valid;
      assign sum_nx  = slice_sum;
    end else begin : g_src
      assign a_in    = g_stg[k-1].g_fwd.a_q;
      assign b_in    = g_stg[k-1].g_fwd.b_q;
      assign c_in    = g_stg[k-1].c_q;
      assign v_in[k] = v_q[k-1];
      assign sum_nx  = {slice_sum, g_stg[k-1].sum_q};
    end

    // Two-level lookahead: group carries as sum-of-products of G/P and c_in.
    always_comb begin
      grp_g     = '0;
      grp_p     = '0;
      grp_c     = '0;
      term      = 1'b0;
      slice_sum = '0;
      for (int j = 0; j < GPS; j++) begin
        {grp_g[j], grp_p[j]} = cla4_gp(a_in[4*j +: 4], b_in[4*j +: 4]);
      end
      grp_c[0] = c_in;
      for (int j = 1; j <= GPS; j++) begin
        term = c_in;
        for (int i = 0; i < j; i++) term = term & grp_p[i];
        grp_c[j] = term;
        for (int i = 0; i < j; i++) begin
          term = grp_g[i];
          for (int m = i + 1; m < j; m++) term = term & grp_p[m];
          grp_c[j] = grp_c[j] | term;
        end
      end
      for (int j = 0; j < GPS; j++) begin
        slice_sum[4*j +: 4] = cla4_sum(a_in[4*j +: 4], b_in[4*j +: 4], grp_c[j]);
      end
    end

    assign upd = load[k] & v_in[k];

    // Commit resolved sum bits and the slice carry when a valid entry arrives.
    always_ff @(posedge clock) begin
      if (clear) begin
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (upd) begin
        sum_q <= sum_nx;
        c_q   <= grp_c[GPS];
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [PW-SW-1:0] a_q;
      logic [PW-SW-1:0] b_q;
      // Carry the not-yet-summed operand bits to the next slice.
      always_ff @(posedge clock) begin
        if (upd) begin
          a_q <= a_in[PW-1:SW];
          b_q <= b_in[PW-1:SW];
        end
      end
    end
  end

  assign s_nx  = g_stg[L].sum_nx;
  assign a_msb = g_stg[L].a_in[SW-1];
  assign b_msb = g_stg[L].b_in[SW-1];
  assign s     = g_stg[L].sum_q;
  assign cout  = g_stg[L].c_q;

  // Flags are formed from the completed sum as it enters the last stage.
  always_ff @(posedge clock) begin
    if (clear) begin
      ovf  <= 1'b0;
      zero <= 1'b0;
      neg  <= 1'b0;
    end else if (load[L] & v_in[L]) begin
      ovf  <= (a_msb == b_msb) & (s_nx[WIDTH-1] != a_msb);
      zero <= ~|s_nx;
      neg  <= s_nx[WIDTH-1];
    end
  end
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: directed vector table, hand-written handshake
// and clear sequences, and a randomized run scored against a queue model.
module tb_cla_addsub_pipe;
  localparam int W = 32;
  localparam int S = 2;

  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;
  } res_t;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         sub;
    logic         use_cin;
    logic         cin;
    res_t         exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         sub;
  logic         use_cin;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic         neg;

  int   total = 0;
  int   bad   = 0;
  res_t q[$];
  res_t e;
  logic stall_prev = 1'b0;
  res_t stall_snap;
  vec_t vecs[11];

  cla_addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clock(clk), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .sub(sub), .use_cin(use_cin), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic, signed range test for overflow.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sb, input logic uc, input logic ci);
    res_t         r;
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         c;
    longint       sa;
    longint       sbb;
    longint       sr;
    longint       hi;
    longint       lo;
    bb     = sb ? ~b : b;
    c      = uc ? ci : sb;
    full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
    r.s    = full[W-1:0];
    r.cout = full[W];
    sa     = $signed(a);
    sbb    = $signed(bb);
    sr     = sa + sbb + (c ? 64'sd1 : 64'sd0);
    hi     = (64'sd1 <<< (W - 1)) - 64'sd1;
    lo     = -(64'sd1 <<< (W - 1));
    r.ovf  = (sr > hi) || (sr < lo);
    r.zero = (r.s == '0);
    r.neg  = r.s[W-1];
    return r;
  endfunction

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic sb,
                              input logic uc, input logic ci, input logic [W-1:0] rs,
                              input logic co, input logic ov, input logic z, input logic n);
    vec_t v;
    v.x = a; v.y = b; v.sub = sb; v.use_cin = uc; v.cin = ci;
    v.exp = {rs, co, ov, z, n};
    return v;
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] corner [5];
    corner[0] = '0;
    corner[1] = '1;
    corner[2] = 32'h8000_0000;
    corner[3] = 32'h7FFF_FFFF;
    corner[4] = 32'h0000_FFFF;
    if ($urandom_range(0, 4) == 0) return corner[$urandom_range(0, 4)];
    return $urandom();
  endfunction

  // Scoreboard: push model results on accept, compare on emit, flush on clear.
  always @(negedge clk) begin
    if (clear) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("stall hold", {out_valid, s, cout, ovf, zero, neg}, {1'b1, stall_snap});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected output", out_valid, 1'b0);
        end else begin
          e = q.pop_front();
          check("result", {s, cout, ovf, zero, neg}, e);
        end
      end
      if (in_valid && in_ready) q.push_back(model(x, y, sub, use_cin, cin));
      stall_prev = out_valid && !out_ready;
      stall_snap = {s, cout, ovf, zero, neg};
    end
  end

  task automatic run_vec(input int idx);
    int lat;
    x = vecs[idx].x; y = vecs[idx].y; sub = vecs[idx].sub;
    use_cin = vecs[idx].use_cin; cin = vecs[idx].cin;
    in_valid = 1'b1; out_ready = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 10);
    check($sformatf("vec%0d latency", idx), lat, S);
    check($sformatf("vec%0d result", idx), {s, cout, ovf, zero, neg}, vecs[idx].exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   acc;
    int   seen;
    res_t hold;

    vecs[0]  = mk(32'hFFFF_FFFF, 32'h1, 0, 0, 0, 32'h0000_0000, 1, 0, 1, 0);
    vecs[1]  = mk(32'h8000_0000, 32'h1, 1, 0, 0, 32'h7FFF_FFFF, 1, 1, 0, 0);
    vecs[2]  = mk(32'h3,         32'h5, 1, 0, 0, 32'hFFFF_FFFE, 0, 0, 0, 1);
    vecs[3]  = mk(32'h1,         32'h0, 0, 1, 1, 32'h0000_0002, 0, 0, 0, 0);
    vecs[4]  = mk(32'h0000_FFFF, 32'h1, 0, 0, 0, 32'h0001_0000, 0, 0, 0, 0);
    vecs[5]  = mk(32'h5,         32'h3, 1, 1, 0, 32'h0000_0001, 1, 0, 0, 0);
    vecs[6]  = mk(32'h7FFF_FFFF, 32'h1, 0, 0, 0, 32'h8000_0000, 0, 1, 0, 1);
    vecs[7]  = mk(32'h0,         32'h0, 1, 0, 0, 32'h0000_0000, 1, 0, 1, 0);
    vecs[8]  = mk(32'h0000_FFFF, 32'h0, 0, 1, 1, 32'h0001_0000, 0, 0, 0, 0);
    vecs[9]  = mk(32'h1234_5678, 32'h1234_5678, 1, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1);
    vecs[10] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 32'hFFFF_FFFE, 1, 0, 0, 1);

    clear = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; sub = 1'b0; use_cin = 1'b0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 clear = 1'b0;
    #1 check("reset state", {in_ready, out_valid, s, cout, ovf, zero, neg}, {2'b10, 36'h0});

    for (int i = 0; i < 11; i++) run_vec(i);

    // Backpressure: with out_ready low only S ops fit, outputs hold.
    out_ready = 1'b0; sub = 1'b0; use_cin = 1'b0; cin = 1'b0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      x = 32'(10 + i); y = 32'h1; in_valid = 1'b1;
      #1 if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp accepted", acc, 2);
    #1 check("bp in_ready low", in_ready, 1'b0);
    hold = {s, cout, ovf, zero, neg};
    repeat (3) @(posedge clk);
    #1 check("bp hold", {out_valid, s, cout, ovf, zero, neg}, {1'b1, hold});
    out_ready = 1'b1; x = 32'd100; y = 32'd1; in_valid = 1'b1;
    #1 check("bp emit1", {in_ready, out_valid, s}, {2'b11, 32'd11});
    @(posedge clk); #1;
    x = 32'd200;
    #1 check("bp emit2", {in_ready, out_valid, s}, {2'b11, 32'd12});
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1 check("bp emit3", {out_valid, s}, {1'b1, 32'd101});
    @(posedge clk); #1;
    check("bp emit4", {out_valid, s}, {1'b1, 32'd201});
    @(posedge clk); #1;
    check("bp drained", out_valid, 1'b0);

    // Clear with two ops in flight; in_valid during clear is ignored.
    out_ready = 1'b0; x = 32'd7; y = 32'd8; in_valid = 1'b1;
    @(posedge clk); #1;
    x = 32'd9;
    @(posedge clk); #1;
    x = 32'd50; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    #1 check("clear outputs", {out_valid, s, cout, ovf, zero, neg}, 37'h0);
    check("clear in_ready", in_ready, 1'b1);
    out_ready = 1'b1; seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("clear no stale", seen, 0);

    // Random traffic with random backpressure and occasional clear.
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      clear     = ($urandom_range(0, 299) == 0);
      x = rand_op(); y = rand_op();
      sub = ($urandom_range(0, 1) == 1);
      use_cin = ($urandom_range(0, 3) == 0);
      cin = ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
    end
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2 * S + 4) @(posedge clk);
    #1 check("drain queue empty", q.size(), 0);
    check("drain out_valid", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
